// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - packed 1-bpp framebuffer reader streaming one pixel per cycle
// Optional feature macro: FB_SCANOUT_LORES_UPSCALE_EN (lores pixels and lines doubled to 128x64)
module fb_scanout (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        hires,
    input  logic [15:0] buf_out,
    output logic [8:0]  buf_addr,
    output logic        buf_enable,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic [6:0]  pix_x,
    output logic [5:0]  pix_y,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        busy
);

`ifdef FB_SCANOUT_LORES_UPSCALE_EN
    localparam logic UPSCALE = 1'b1;
`else
    localparam logic UPSCALE = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Frame mode, captured only when a frame starts
    logic        r_hires;

    // Fetcher: sequence index counts reads issued this frame
    logic [9:0]  r_fetch_idx;
    logic [8:0]  r_buf_addr;
    logic        r_buf_enable;
    logic        r_rd_pend;

    // Two-entry word FIFO between the read port and the shifter
    logic [15:0] r_fifo [2];
    logic        r_fifo_wr;
    logic        r_fifo_rd;
    logic [1:0]  r_fifo_cnt;

    // Shifter and output coordinates
    logic [15:0] r_shift;
    logic [3:0]  r_bit;
    logic        r_rep;
    logic        r_pix_valid;
    logic [6:0]  r_pix_x;
    logic [5:0]  r_pix_y;

    logic        w_start;
    logic        w_up;
    logic [6:0]  w_x_end;
    logic [5:0]  w_y_end;
    logic        w_at_eol;
    logic        w_at_eof;
    logic        w_accept;
    logic        w_last_slot;
    logic        w_word_done;
    logic        w_frame_end;
    logic        w_need_word;
    logic        w_word_avail;
    logic        w_load;
    logic        w_pop_fifo;
    logic        w_bypass;
    logic        w_push;
    logic [15:0] w_load_word;
    logic [1:0]  w_occ_next;
    logic [9:0]  w_last_idx;
    logic        w_issue;
    logic [8:0]  w_fetch_addr;

    assign w_start      = (r_state == S_IDLE) && enable;
    // Upscaled lores behaves like a 128x64 output frame fed from 4-word lines
    assign w_up         = UPSCALE & ~r_hires;
    assign w_x_end      = (w_up || r_hires) ? 7'd127 : 7'd63;
    assign w_y_end      = (w_up || r_hires) ? 6'd63  : 6'd31;
    assign w_at_eol     = (r_pix_x == w_x_end);
    assign w_at_eof     = w_at_eol && (r_pix_y == w_y_end);
    assign w_accept     = r_pix_valid && pix_ready;

    // A word is finished after its 16th bit (each bit shown twice when upscaling)
    assign w_last_slot  = (r_bit == 4'd15) && (!w_up || r_rep);
    assign w_word_done  = w_accept && w_last_slot;
    assign w_frame_end  = w_accept && w_at_eof;

    // Load a new word when the shifter is empty or just drained, never past the frame end
    assign w_need_word  = (r_state == S_RUN) && (!r_pix_valid || w_word_done) && !w_frame_end;
    assign w_word_avail = (r_fifo_cnt != 2'd0) || r_rd_pend;
    assign w_load       = w_need_word && w_word_avail;
    assign w_pop_fifo   = w_load && (r_fifo_cnt != 2'd0);
    // Returning data goes straight to the shifter when nothing is queued ahead of it
    assign w_bypass     = w_load && (r_fifo_cnt == 2'd0);
    assign w_push       = r_rd_pend && !w_bypass;
    assign w_load_word  = (r_fifo_cnt != 2'd0) ? r_fifo[r_fifo_rd] : buf_out;
    assign w_occ_next   = r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop_fifo};

    // Buffered plus outstanding words never exceed two, so the FIFO cannot overflow
    assign w_last_idx   = w_up ? 10'd255 : (r_hires ? 10'd511 : 10'd127);
    assign w_issue      = (r_state == S_RUN) && (r_fetch_idx <= w_last_idx)
                        && (({1'b0, w_occ_next} + {2'b00, r_buf_enable}) < 3'd2);
    // Upscaled sequence reads each 4-word line twice: index bit 2 selects the repeat
    assign w_fetch_addr = w_up ? {2'b00, r_fetch_idx[7:3], r_fetch_idx[1:0]} : r_fetch_idx[8:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE waits for enable, RUN ends on the accepted eof pixel
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (enable) w_state_next = S_RUN;
            S_RUN:  if (w_frame_end) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Frame mode latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hires <= 1'b0;
        end else if (w_start) begin
            r_hires <= hires;
        end
    end

    // Read issue: first read goes out with the frame start, later ones when space allows
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_enable <= 1'b0;
            r_buf_addr   <= 9'd0;
            r_fetch_idx  <= 10'd0;
            r_rd_pend    <= 1'b0;
        end else if (w_start) begin
            r_buf_enable <= 1'b1;
            r_buf_addr   <= 9'd0;
            r_fetch_idx  <= 10'd1;
            r_rd_pend    <= 1'b0;
        end else begin
            r_rd_pend <= r_buf_enable;
            if (w_issue) begin
                r_buf_enable <= 1'b1;
                r_buf_addr   <= w_fetch_addr;
                r_fetch_idx  <= r_fetch_idx + 10'd1;
            end else begin
                r_buf_enable <= 1'b0;
            end
        end
    end

    // Word FIFO push/pop
    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_fifo[0]  <= 16'd0;
            r_fifo[1]  <= 16'd0;
            r_fifo_wr  <= 1'b0;
            r_fifo_rd  <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_fifo_wr] <= buf_out;
                r_fifo_wr         <= ~r_fifo_wr;
            end
            if (w_pop_fifo) begin
                r_fifo_rd <= ~r_fifo_rd;
            end
            r_fifo_cnt <= w_occ_next;
        end
    end

    // Shifter: advance on accept, reload at word end or drop valid if starved
    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_shift     <= 16'd0;
            r_bit       <= 4'd0;
            r_rep       <= 1'b0;
            r_pix_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_up && !r_rep) begin
                    r_rep <= 1'b1;
                end else begin
                    r_shift <= {r_shift[14:0], 1'b0};
                    r_bit   <= r_bit + 4'd1;
                    r_rep   <= 1'b0;
                end
                if (w_last_slot) begin
                    r_pix_valid <= 1'b0;
                end
            end
            if (w_load) begin
                r_shift     <= w_load_word;
                r_bit       <= 4'd0;
                r_rep       <= 1'b0;
                r_pix_valid <= 1'b1;
            end
        end
    end

    // Output coordinates: column wraps at line end and bumps the row
    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_pix_x <= 7'd0;
            r_pix_y <= 6'd0;
        end else if (w_accept) begin
            if (w_at_eol) begin
                r_pix_x <= 7'd0;
                r_pix_y <= (r_pix_y == w_y_end) ? 6'd0 : r_pix_y + 6'd1;
            end else begin
                r_pix_x <= r_pix_x + 7'd1;
            end
        end
    end

    assign buf_addr   = r_buf_addr;
    assign buf_enable = r_buf_enable;
    assign pix_valid  = r_pix_valid;
    assign pix_data   = r_shift[15];
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_eol    = r_pix_valid && w_at_eol;
    assign pix_eof    = r_pix_valid && w_at_eof;
    assign busy       = (r_state == S_RUN);

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - self-checking bench for fb_scanout
module tb_fb_scanout;

`ifdef FB_SCANOUT_LORES_UPSCALE_EN
    localparam bit UP = 1'b1;
`else
    localparam bit UP = 1'b0;
`endif
    localparam int BOUND = 40000;

    typedef struct {
        int n;
        int x;
        int y;
        bit d;
        bit eol;
        bit eof;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        hires = 1'b0;
    logic        pix_ready = 1'b0;
    logic [15:0] buf_out;
    logic [8:0]  buf_addr;
    logic        buf_enable;
    logic        pix_valid;
    logic        pix_data;
    logic [6:0]  pix_x;
    logic [5:0]  pix_y;
    logic        pix_eol;
    logic        pix_eof;
    logic        busy;

    always #5 clk = ~clk;

    fb_scanout dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .hires      (hires),
        .buf_out    (buf_out),
        .buf_addr   (buf_addr),
        .buf_enable (buf_enable),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .busy       (busy)
    );

    // Framebuffer RAM: data valid the cycle after the read strobe
    logic [15:0] mem [512];
    logic [15:0] rd_q = 16'h0;
    always @(posedge clk) if (buf_enable) rd_q <= mem[buf_addr];
    assign buf_out = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Reference rules for a frame of a given mode
    function automatic int fw(input bit h);
        return (h || UP) ? 128 : 64;
    endfunction
    function automatic int fh(input bit h);
        return (h || UP) ? 64 : 32;
    endfunction
    function automatic int last_word(input bit h);
        return h ? 511 : 127;
    endfunction
    function automatic int ppw(input bit h);
        return (!h && UP) ? 32 : 16;
    endfunction
    function automatic bit exp_pix(input bit h, input int x, input int y);
        logic [15:0] w;
        int b;
        if (!h && UP) begin
            w = mem[(y / 2) * 4 + (x / 2) / 16];
            b = 15 - (x / 2) % 16;
        end else begin
            w = mem[y * (h ? 8 : 4) + x / 16];
            b = 15 - x % 16;
        end
        return w[b];
    endfunction

    // Monitor state
    bit          f_h;
    int          cap_n;
    bit          cap_d   [8192];
    int          cap_x   [8192];
    int          cap_y   [8192];
    bit          cap_eol [8192];
    bit          cap_eof [8192];
    int          first_valid_cyc, first_be_cyc, first_be_addr, eof_cyc;
    int          busy_at_first, busy_after_eof;
    int          issued, stall_viol, pf_viol, addr_viol;
    bit          prev_v, prev_r;
    logic [16:0] prev_f;

    task automatic clear_mon();
        cap_n = 0;
        first_valid_cyc = -1;
        first_be_cyc = -1;
        first_be_addr = -1;
        eof_cyc = -1;
        busy_at_first = -1;
        busy_after_eof = -1;
        issued = 0;
        stall_viol = 0;
        pf_viol = 0;
        addr_viol = 0;
        prev_v = 1'b0;
    endtask

    always @(negedge clk) begin
        int started;
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r &&
                {pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_eof} !== prev_f)
                stall_viol++;
            if (buf_enable) begin
                if (first_be_cyc < 0) begin
                    first_be_cyc = cyc;
                    first_be_addr = int'(buf_addr);
                end
                if (int'(buf_addr) > last_word(f_h)) addr_viol++;
                issued++;
            end
            started = pix_valid ? cap_n / ppw(f_h) + 1 : cap_n / ppw(f_h);
            if (issued - started > 2) pf_viol++;
            if (eof_cyc >= 0 && cyc == eof_cyc + 1) busy_after_eof = int'(busy);
            if (pix_valid && first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                busy_at_first = int'(busy);
            end
            if (pix_valid && pix_ready) begin
                if (cap_n < 8192) begin
                    cap_d[cap_n]   = pix_data;
                    cap_x[cap_n]   = int'(pix_x);
                    cap_y[cap_n]   = int'(pix_y);
                    cap_eol[cap_n] = pix_eol;
                    cap_eof[cap_n] = pix_eof;
                end
                if (pix_eof && eof_cyc < 0) eof_cyc = cyc;
                cap_n++;
            end
            prev_v = pix_valid;
            prev_r = pix_ready;
            prev_f = {pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_eof};
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic start_frame(input bit h, output int c0);
        @(posedge clk);
        #1;
        clear_mon();
        f_h = h;
        hires = h;
        enable = 1'b1;
        pix_ready = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wait_eof(input int pct, input int toggle_at, output bit to);
        to = 1'b1;
        for (int k = 0; k < BOUND; k++) begin
            @(posedge clk);
            #1;
            pix_ready = ($urandom_range(0, 99) < pct);
            if (toggle_at >= 0 && cap_n >= toggle_at) hires = 1'b1;
            if (eof_cyc >= 0) begin
                to = 1'b0;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        int n_exp;
        int errs;
        n_exp = fw(f_h) * fh(f_h);
        check({tag, "_count"}, cap_n, n_exp);
        errs = 0;
        for (int n = 0; n < cap_n && n < 8192; n++) begin
            int x;
            int y;
            x = n % fw(f_h);
            y = n / fw(f_h);
            if (cap_x[n] != x || cap_y[n] != y || cap_d[n] != exp_pix(f_h, x, y) ||
                cap_eol[n] != (x == fw(f_h) - 1) || cap_eof[n] != (n == n_exp - 1))
                errs++;
        end
        check({tag, "_pixels"}, errs, 0);
        check({tag, "_stable"}, stall_viol, 0);
        check({tag, "_prefetch"}, pf_viol, 0);
        check({tag, "_addr"}, addr_viol, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom());
    endtask

    function automatic int out_vec();
        return int'({buf_addr, buf_enable, pix_valid, pix_data, pix_x, pix_y,
                     pix_eol, pix_eof, busy});
    endfunction

    initial begin
        vec_t tab [8];
        int   c0;
        bit   to;
        int   ones;
        int   nl;

        if (UP) begin
            tab[0] = '{0,    0,   0,  1'b1, 1'b0, 1'b0};
            tab[1] = '{3,    3,   0,  1'b1, 1'b0, 1'b0};
            tab[2] = '{4,    4,   0,  1'b0, 1'b0, 1'b0};
            tab[3] = '{127,  127, 0,  1'b0, 1'b1, 1'b0};
            tab[4] = '{128,  0,   1,  1'b1, 1'b0, 1'b0};
            tab[5] = '{131,  3,   1,  1'b1, 1'b0, 1'b0};
            tab[6] = '{256,  0,   2,  1'b0, 1'b0, 1'b0};
            tab[7] = '{8191, 127, 63, 1'b0, 1'b1, 1'b1};
        end else begin
            tab[0] = '{0,    0,   0,  1'b1, 1'b0, 1'b0};
            tab[1] = '{1,    1,   0,  1'b0, 1'b0, 1'b0};
            tab[2] = '{14,   14,  0,  1'b0, 1'b0, 1'b0};
            tab[3] = '{15,   15,  0,  1'b1, 1'b0, 1'b0};
            tab[4] = '{16,   16,  0,  1'b0, 1'b0, 1'b0};
            tab[5] = '{63,   63,  0,  1'b0, 1'b1, 1'b0};
            tab[6] = '{64,   0,   1,  1'b0, 1'b0, 1'b0};
            tab[7] = '{2047, 63,  31, 1'b0, 1'b1, 1'b1};
        end

        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
        clear_mon();
        f_h = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", out_vec(), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Lores single-word image: latency, markers and table of pixels
        mem[0] = UP ? 16'hC000 : 16'h8001;
        nl = fw(1'b0) * fh(1'b0);
        start_frame(1'b0, c0);
        wait_eof(100, -1, to);
        check("t1_timeout", int'(to), 0);
        check("t1_first_read", first_be_cyc - c0, 1);
        check("t1_first_addr", first_be_addr, 0);
        check("t1_first_valid", first_valid_cyc - c0, 3);
        check("t1_busy_run", busy_at_first, 1);
        check("t1_eof_cycle", eof_cyc - c0, nl + 2);
        check("t1_busy_done", busy_after_eof, 0);
        for (int i = 0; i < 8; i++) begin
            int n;
            n = tab[i].n;
            check($sformatf("tab%0d_x", i), cap_x[n], tab[i].x);
            check($sformatf("tab%0d_y", i), cap_y[n], tab[i].y);
            check($sformatf("tab%0d_d", i), int'(cap_d[n]), int'(tab[i].d));
            check($sformatf("tab%0d_eol", i), int'(cap_eol[n]), int'(tab[i].eol));
            check($sformatf("tab%0d_eof", i), int'(cap_eof[n]), int'(tab[i].eof));
        end
        check_frame("t1");

        // Hires with only the very last pixel set
        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
        mem[511] = 16'h0001;
        start_frame(1'b1, c0);
        wait_eof(100, -1, to);
        check("t2_timeout", int'(to), 0);
        check_frame("t2");
        ones = 0;
        for (int n = 0; n < 8192; n++) ones += int'(cap_d[n]);
        check("t2_ones", ones, 1);
        check("t2_last_pix", int'(cap_d[8191]), 1);
        check("t2_last_eof", int'(cap_eof[8191]), 1);

        // Lores random image at full rate: no bubbles
        fill_random();
        start_frame(1'b0, c0);
        wait_eof(100, -1, to);
        check("t3_timeout", int'(to), 0);
        check("t3_eof_cycle", eof_cyc - c0, nl + 2);
        check_frame("t3");

        // Hires random image with 50% backpressure
        fill_random();
        start_frame(1'b1, c0);
        wait_eof(50, -1, to);
        check("t4_timeout", int'(to), 0);
        check_frame("t4");

        // hires raised mid lores frame takes effect only on the next frame
        fill_random();
        start_frame(1'b0, c0);
        wait_eof(100, 1000, to);
        check("t5a_timeout", int'(to), 0);
        check_frame("t5a");
        start_frame(1'b1, c0);
        wait_eof(100, -1, to);
        check("t5b_timeout", int'(to), 0);
        check_frame("t5b");

        // Reset mid-frame aborts; a fresh frame restarts cleanly
        fill_random();
        start_frame(1'b0, c0);
        for (int k = 0; k < BOUND; k++) begin
            @(posedge clk);
            #1;
            if (cap_n >= 500) break;
        end
        check("t6_reach", int'(cap_n >= 500), 1);
        reset = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_reset_outputs", out_vec(), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fill_random();
        start_frame(1'b0, c0);
        wait_eof(100, -1, to);
        check("t6_timeout", int'(to), 0);
        check("t6_first_valid", first_valid_cyc - c0, 3);
        check("t6_first_pix", int'(cap_d[0]), int'(mem[0][15]));
        check_frame("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
